// File: rtl/spi_arb_pkg.sv
// Shared constants for the two-client SPI bus arbiter: client count, byte width,
// phase counter width and the arbiter state encoding.
package spi_arb_pkg;

    localparam int unsigned NUM_CLIENTS = 2;
    localparam int unsigned SPI_W       = 8;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned ST_W        = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_SETUP = 3'd1;
    localparam logic [ST_W-1:0] ST_OWN   = 3'd2;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [ST_W-1:0] ST_HOLD  = 3'd4;

endpackage

// File: rtl/spi_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, and on a tie the
// client that did not own the bus last wins.
module rr_pick2
    import spi_arb_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   last,
    output logic [NUM_CLIENTS-1:0] win_c,
    output logic                   valid_c
);

    always_comb begin
        win_c = req;
        if (req == 2'b11) begin
            win_c = last ? 2'b01 : 2'b10;
        end
    end

    assign valid_c = |req;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI byte engine between two client controllers: round-robin grant,
// per-client chip select with setup/hold spacing, and byte strobe/data routing.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] req,
    output logic [NUM_CLIENTS-1:0] grant,
    input  logic [NUM_CLIENTS-1:0] byte_begin,
    input  logic [SPI_W-1:0]       tx_data0,
    input  logic [SPI_W-1:0]       tx_data1,
    output logic [NUM_CLIENTS-1:0] byte_done,
    output logic [SPI_W-1:0]       rx_data,
    output logic [NUM_CLIENTS-1:0] cs_n,
    output logic                   spi_tx_begin,
    output logic [SPI_W-1:0]       spi_tx_data,
    input  logic                   spi_tx_end,
    input  logic [SPI_W-1:0]       spi_rx_data
);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD - 1);

    logic [ST_W-1:0]        state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic                   owner, owner_d;
    logic                   last, last_d;
    logic                   busy, busy_d;
    logic                   hold_gap, hold_gap_d;
    logic [NUM_CLIENTS-1:0] grant_d, cs_n_d, byte_done_d;
    logic [SPI_W-1:0]       rx_data_d, spi_tx_data_d;
    logic                   spi_tx_begin_d;
    logic [NUM_CLIENTS-1:0] pick_c;
    logic                   pick_valid_c;
    logic [NUM_CLIENTS-1:0] owner_oh_c;
    logic                   tx_done_c;

    rr_pick2 u_pick (
        .req     (req),
        .last    (last),
        .win_c   (pick_c),
        .valid_c (pick_valid_c)
    );

    assign owner_oh_c = NUM_CLIENTS'(1'b1) << owner;
    assign tx_done_c  = busy && spi_tx_end;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            owner        <= 1'b0;
            last         <= 1'b1;
            busy         <= 1'b0;
            hold_gap     <= 1'b0;
            grant        <= '0;
            cs_n         <= '1;
            byte_done    <= '0;
            rx_data      <= '0;
            spi_tx_begin <= 1'b0;
            spi_tx_data  <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            owner        <= owner_d;
            last         <= last_d;
            busy         <= busy_d;
            hold_gap     <= hold_gap_d;
            grant        <= grant_d;
            cs_n         <= cs_n_d;
            byte_done    <= byte_done_d;
            rx_data      <= rx_data_d;
            spi_tx_begin <= spi_tx_begin_d;
            spi_tx_data  <= spi_tx_data_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        owner_d        = owner;
        last_d         = last;
        busy_d         = busy;
        hold_gap_d     = hold_gap;
        grant_d        = grant;
        cs_n_d         = cs_n;
        byte_done_d    = '0;
        rx_data_d      = rx_data;
        spi_tx_begin_d = 1'b0;
        spi_tx_data_d  = spi_tx_data;

        // busy is only ever set in OWN and cleared before DRAIN exits.
        if (tx_done_c) begin
            rx_data_d   = spi_rx_data;
            byte_done_d = owner_oh_c;
            busy_d      = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    owner_d = pick_c[1];
                    cs_n_d  = ~pick_c;
                    cnt_d   = SETUP_LOAD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    grant_d = owner_oh_c;
                    last_d  = owner;
                    state_d = ST_OWN;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_OWN: begin
                if (!req[owner]) begin
                    grant_d = '0;
                    if (busy && !spi_tx_end) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d      = HOLD_LOAD;
                        hold_gap_d = 1'b0;
                        state_d    = ST_HOLD;
                    end
                end else if (byte_begin[owner] && !busy) begin
                    spi_tx_data_d  = owner ? tx_data1 : tx_data0;
                    spi_tx_begin_d = 1'b1;
                    busy_d         = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (spi_tx_end) begin
                    cnt_d      = HOLD_LOAD;
                    hold_gap_d = 1'b0;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // First pass keeps cs_n low; second pass is the deselected gap.
                if (cnt == '0) begin
                    if (!hold_gap) begin
                        cs_n_d     = '1;
                        cnt_d      = HOLD_LOAD;
                        hold_gap_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a scoreboard of expected engine bytes
// and expected completions, checked whenever the DUT strobes them.
module tb_spi_bus_arbiter;
    import spi_arb_pkg::*;

    localparam int unsigned S = 4;
    localparam int unsigned H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [1:0] grant;
    logic [1:0] byte_begin = '0;
    logic [7:0] tx_data0 = '0;
    logic [7:0] tx_data1 = '0;
    logic [1:0] byte_done;
    logic [7:0] rx_data;
    logic [1:0] cs_n;
    logic       spi_tx_begin;
    logic [7:0] spi_tx_data;
    logic       spi_tx_end = 1'b0;
    logic [7:0] spi_rx_data = '0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int low_run[2] = '{0, 0};
    bit check_low = 1'b0;
    bit both_low = 1'b0;
    logic [7:0] txq[$];
    logic [9:0] doneq[$];
    int t0, t1;
    logic [1:0] exp_g;

    spi_bus_arbiter #(.CS_SETUP(S), .CS_HOLD(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .byte_begin   (byte_begin),
        .tx_data0     (tx_data0),
        .tx_data1     (tx_data1),
        .byte_done    (byte_done),
        .rx_data      (rx_data),
        .cs_n         (cs_n),
        .spi_tx_begin (spi_tx_begin),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_end   (spi_tx_end),
        .spi_rx_data  (spi_rx_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle scoreboard pops and chip-select bookkeeping.
    task automatic monitor();
        logic [9:0] e;
        cyc++;
        if (cs_n === 2'b00) both_low = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (cs_n[i] === 1'b0) begin
                low_run[i]++;
            end else begin
                if (check_low && low_run[i] != 0)
                    chk("cs_low_time", 32'(low_run[i] >= int'(S + H)), 32'd1);
                low_run[i] = 0;
            end
        end
        if (spi_tx_begin !== 1'b0) begin
            if (txq.size() == 0) chk("spi_tx_begin_unexpected", 32'(spi_tx_begin), 32'd0);
            else chk("spi_tx_data", 32'(spi_tx_data), 32'(txq.pop_front()));
        end
        if (byte_done !== 2'b00) begin
            if (doneq.size() == 0) begin
                chk("byte_done_unexpected", 32'(byte_done), 32'd0);
            end else begin
                e = doneq.pop_front();
                chk("byte_done", 32'(byte_done), 32'(e[9:8]));
                chk("rx_data", 32'(rx_data), 32'(e[7:0]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_cs(input logic [1:0] target, input string tag);
        int n = 0;
        while (cs_n !== target && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(cs_n), 32'(target));
    endtask

    task automatic wait_grant(input logic [1:0] target, input string tag);
        int n = 0;
        while (grant !== target && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(grant), 32'(target));
    endtask

    task automatic start_byte(input int c, input logic [7:0] d);
        byte_begin[c] = 1'b1;
        if (c == 0) tx_data0 = d; else tx_data1 = d;
        txq.push_back(d);
        tick();
        byte_begin = '0;
    endtask

    task automatic end_byte(input int c, input logic [7:0] d, input bit drop);
        spi_tx_end  = 1'b1;
        spi_rx_data = d;
        if (drop) req[c] = 1'b0;
        doneq.push_back({2'(1 << c), d});
        tick();
        spi_tx_end = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        do_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'h3);
        chk("rst_byte_done", 32'(byte_done), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_spi_tx_begin", 32'(spi_tx_begin), 32'd0);
        chk("rst_spi_tx_data", 32'(spi_tx_data), 32'd0);

        // Client 0 alone, two bytes.
        req = 2'b01;
        wait_cs(2'b10, "t1_cs_fall");
        t0 = cyc;
        wait_grant(2'b01, "t1_grant");
        chk("t1_setup_cycles", 32'(cyc - t0), 32'(S));
        start_byte(0, 8'h8F);
        tick();
        tick();
        end_byte(0, 8'hD3, 1'b0);
        start_byte(0, 8'h00);
        tick();
        end_byte(0, 8'h0F, 1'b1);
        t1 = cyc;
        chk("t1_grant_cleared", 32'(grant), 32'd0);
        wait_cs(2'b11, "t1_cs_rise");
        chk("t1_hold_cycles", 32'(cyc - t1), 32'(H));

        // Tie after reset: client 0 first, then client 1.
        req = 2'b11;
        do_reset();
        wait_grant(2'b01, "t2_first_grant");
        req = 2'b10;
        wait_cs(2'b11, "t2_cs_release");
        t0 = cyc;
        wait_cs(2'b01, "t2_cs1_fall");
        chk("t2_gap_cycles", 32'(cyc - t0), 32'(H + 1));
        t0 = cyc;
        wait_grant(2'b10, "t2_second_grant");
        chk("t2_setup_cycles", 32'(cyc - t0), 32'(S));
        req = 2'b00;

        // Release with a byte in flight goes through DRAIN.
        do_reset();
        req = 2'b01;
        wait_grant(2'b01, "t3_grant");
        start_byte(0, 8'h12);
        req = 2'b00;
        tick();
        chk("t3_state_drain", 32'(dut.state), 32'(ST_DRAIN));
        chk("t3_grant_cleared", 32'(grant), 32'd0);
        tick();
        chk("t3_cs_held", 32'(cs_n), 32'h2);
        end_byte(0, 8'hA5, 1'b0);
        t1 = cyc;
        chk("t3_state_hold", 32'(dut.state), 32'(ST_HOLD));
        wait_cs(2'b11, "t3_cs_rise");
        chk("t3_hold_cycles", 32'(cyc - t1), 32'(H));

        // Ignored strobes: non-owner, and owner while busy.
        do_reset();
        req = 2'b01;
        wait_grant(2'b01, "t4_grant");
        byte_begin[1] = 1'b1;
        tx_data1 = 8'h77;
        tick();
        byte_begin = '0;
        chk("t4_nonowner_begin", 32'(spi_tx_begin), 32'd0);
        chk("t4_nonowner_data", 32'(spi_tx_data), 32'd0);
        start_byte(0, 8'h3C);
        byte_begin[0] = 1'b1;
        tx_data0 = 8'h99;
        tick();
        byte_begin = '0;
        chk("t4_busy_begin", 32'(spi_tx_begin), 32'd0);
        chk("t4_busy_data", 32'(spi_tx_data), 32'h3C);
        end_byte(0, 8'h5A, 1'b0);

        // Reset with a byte in flight.
        start_byte(0, 8'h11);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b00;
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_cs_n", 32'(cs_n), 32'h3);
        chk("t5_byte_done", 32'(byte_done), 32'd0);
        chk("t5_rx_data", 32'(rx_data), 32'd0);
        chk("t5_spi_tx_begin", 32'(spi_tx_begin), 32'd0);
        spi_tx_end = 1'b1;
        spi_rx_data = 8'hEE;
        tick();
        spi_tx_end = 1'b0;
        tick();
        chk("t5_stray_end_done", 32'(byte_done), 32'd0);
        chk("t5_stray_end_rx", 32'(rx_data), 32'd0);

        // Fairness: both clients re-request on every release.
        req = 2'b11;
        do_reset();
        check_low = 1'b1;
        exp_g = 2'b01;
        for (int k = 0; k < 10; k++) begin
            wait_grant(exp_g, "t6_grant_order");
            req = req & ~exp_g;
            tick();
            req = 2'b11;
            exp_g = ~exp_g;
        end
        req = 2'b00;
        wait_cs(2'b11, "t6_final_release");
        tick();
        check_low = 1'b0;

        chk("cs_never_both_low", 32'(both_low), 32'd0);
        chk("txq_drained", 32'(txq.size()), 32'd0);
        chk("doneq_drained", 32'(doneq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
